fir_coeff_sequencer: RTL
========================

Name: fir_coeff_sequencer

Overview:
- Controller between the host coefficient-write port, the coefficient single-port SRAM and the direct-form FIR datapath.
- Owns the SRAM for the whole update cycle. Two phases:
  - Host-write phase: host writes are gated and forwarded to the SRAM.
  - Load phase: the coefficients are read back sequentially and presented as indexed write strobes into the tap coefficient register bank.
- Gates the delay line and accumulator so the filter only runs on a fully loaded, consistent coefficient set.

Parameters:
- COEFF_W, 16, coefficient and SRAM data width.
- NUM_TAPS, 33, number of coefficients loaded per update.
- ADDR_W, 6, SRAM address width.
- BASE_ADDR, 2, SRAM address of tap 1; tap k is at BASE_ADDR+k-1.

Ports:
- iClk_12M  in  1  single system clock, 12 MHz.
- iRsn  in  1  reset, synchronous, active-low.
- iCoeffiUpdateFlag  in  1  high = host coefficient-update window open.
- iCsnRam  in  1  host chip select, active-low.
- iWrnRam  in  1  host write-not, 0 = write.
- iAddrRam  in  ADDR_W  host SRAM address.
- iWrDtRam  in  COEFF_W  host write data.
- oCsnRam  out  1  SRAM chip select, active-low.
- oWrnRam  out  1  SRAM write-not.
- oAddrRam  out  ADDR_W  SRAM address.
- oWrDtRam  out  COEFF_W  SRAM write data.
- iRdDtRam  in  COEFF_W  SRAM read data, valid the cycle after a read request.
- oCoeffWe  out  1  coefficient register write strobe.
- oCoeffIdx  out  6  tap index, 1..NUM_TAPS.
- oCoeffDt  out  COEFF_W  coefficient value.
- oEnDelay  out  1  delay-line shift enable.
- oEnAcc  out  1  accumulator enable.
- oBusy  out  1  high in HOST_WR or LOAD.
- oDone  out  1  one-cycle pulse when a load completes.

Behaviour:
- All outputs are registered.
- Reset (iRsn=0 at a clock edge), including mid-operation:
  - state=IDLE
  - oCsnRam=1, oWrnRam=1, oAddrRam=0, oWrDtRam=0
  - oCoeffWe=0, oCoeffIdx=0, oCoeffDt=0
  - oEnDelay=0, oEnAcc=0, oBusy=0, oDone=0
  - internal counter=0
- States: IDLE, HOST_WR, LOAD, RUN.
- IDLE:
  - SRAM deselected; filter disabled.
  - iCoeffiUpdateFlag=1 -> HOST_WR.
- HOST_WR:
  - Host SRAM signals are forwarded with 1-cycle latency.
  - oCsnRam=0 only when iCsnRam=0, iWrnRam=0 and iAddrRam is within [BASE_ADDR, BASE_ADDR+NUM_TAPS-1]. Otherwise oCsnRam=1.
  - Host reads and out-of-range writes are dropped.
  - oEnDelay=0, oEnAcc=0.
  - iCoeffiUpdateFlag=0 -> LOAD, counter=0.
- LOAD:
  - Read requests are issued on consecutive cycles: oCsnRam=0, oWrnRam=1, oAddrRam=BASE_ADDR+counter, for counter 0..NUM_TAPS-1.
  - The cycle after each request: oCoeffWe=1, oCoeffIdx=counter+1 (of that request), oCoeffDt=iRdDtRam.
  - Duration is NUM_TAPS+1 cycles: 33 requests, and the last strobe lands one cycle after the last request.
  - Host inputs are ignored during LOAD.
  - The update flag is not sampled during LOAD; a load always completes.
  - On the cycle after the last oCoeffWe: state=RUN, oDone=1 for one cycle, oEnDelay=1, oEnAcc=1.
- RUN:
  - oEnDelay=oEnAcc=1 every cycle; SRAM deselected.
  - iCoeffiUpdateFlag=1 -> HOST_WR, with oEnDelay and oEnAcc low from the next cycle.
  - Delay-line contents are preserved; only shifting stops.
- Flag already high on entry to RUN: RUN lasts exactly one cycle (oDone still pulses), then HOST_WR.
- oBusy=1 exactly while state is HOST_WR or LOAD.
- Counter is ADDR_W wide and never wraps. The terminal compare is counter==NUM_TAPS-1.

Optional Feature:
- Macro: FIR_COEFF_CHECKSUM_EN.
- Defined:
  - Adds output port oChecksum, COEFF_W+6 bits.
  - Running sign-extended sum of every oCoeffDt strobed in the current LOAD.
  - Cleared on entry to LOAD and on reset; held stable from the oDone cycle until the next LOAD.
- Undefined: port and adder are absent; all other behaviour is identical.

Test Plan:
- Reset hold: iRsn=0 for 3 cycles mid-LOAD -> all outputs at reset values after the first edge; state=IDLE.
- Host write window: flag=1, write 0x1234 to addr 2 and 0xABCD to addr 34 -> oCsnRam=0, oWrnRam=0 with matching address/data one cycle later. Writes to addr 1 and 35 -> oCsnRam stays 1.
- Load sequence:
  - Stimulus: SRAM preloaded with addr n = n*3, flag falls.
  - oAddrRam steps 2..34 on 33 consecutive cycles.
  - oCoeffWe is high for 33 consecutive cycles, with oCoeffIdx 1..33 and oCoeffDt 6..102.
  - oDone pulses once, on the next cycle.
- Run gating: after oDone, oEnAcc and oEnDelay stay high for 100 cycles. Raising the flag -> both low the next cycle, oBusy=1.
- Flag during LOAD: flag rises at load cycle 10 -> load still completes all 33 strobes; exactly one RUN cycle with oDone=1, then HOST_WR.
- Checksum (FIR_COEFF_CHECKSUM_EN): load all 33 coefficients = 0xFFFF (-1) -> oChecksum = -33, i.e. 0x3FFFDF in 22 bits.

Source files
------------

// File: rtl/fir_coeff_sequencer.sv
// Coefficient update controller: host SRAM write window, sequential tap load, FIR run gating.
// Latency: host writes reach the SRAM one cycle after they are presented; tap strobes trail SRAM reads by one cycle.
// Backpressure: none; host traffic outside HOST_WR is dropped and a started load always runs to completion.
// Optional feature macro: FIR_COEFF_CHECKSUM_EN adds oChecksum, the signed sum of the taps strobed by the current load.

module fir_coeff_sequencer #(
  parameter int COEFF_W   = 16,
  parameter int NUM_TAPS  = 33,
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 2
) (
  input  logic               iClk_12M,
  input  logic               iRsn,
  input  logic               iCoeffiUpdateFlag,
  input  logic               iCsnRam,
  input  logic               iWrnRam,
  input  logic [ADDR_W-1:0]  iAddrRam,
  input  logic [COEFF_W-1:0] iWrDtRam,
  output logic               oCsnRam,
  output logic               oWrnRam,
  output logic [ADDR_W-1:0]  oAddrRam,
  output logic [COEFF_W-1:0] oWrDtRam,
  input  logic [COEFF_W-1:0] iRdDtRam,
  output logic               oCoeffWe,
  output logic [5:0]         oCoeffIdx,
  output logic [COEFF_W-1:0] oCoeffDt,
  output logic               oEnDelay,
  output logic               oEnAcc,
  output logic               oBusy,
  output logic               oDone
`ifdef FIR_COEFF_CHECKSUM_EN
  ,
  output logic [COEFF_W+5:0] oChecksum
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOST_WR = 2'd1,
    LOAD    = 2'd2,
    RUN     = 2'd3
  } state_t;

  // Address window holding the tap coefficients, and the counter value of the last read.
  localparam logic [ADDR_W-1:0] LO_ADDR  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] HI_ADDR  = ADDR_W'(BASE_ADDR + NUM_TAPS - 1);
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                csn_q, csn_d;
  logic                wrn_q, wrn_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COEFF_W-1:0]  wdat_q, wdat_d;
  logic                we_q, we_d;
  logic [5:0]          idx_q, idx_d;
  logic                en_q, en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                host_wr_ok;
  logic                load_entry;

  // Only host writes that land inside the coefficient window are allowed through to the SRAM.
  assign host_wr_ok = !iCsnRam && !iWrnRam && (iAddrRam >= LO_ADDR) && (iAddrRam <= HI_ADDR);
  assign load_entry = (state_q == HOST_WR) && (state_d == LOAD);

  // Next-state and next-output logic; the SRAM is deselected unless a cycle explicitly selects it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    csn_d   = 1'b1;
    wrn_d   = 1'b1;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    we_d    = 1'b0;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (iCoeffiUpdateFlag) state_d = HOST_WR;
      end
      HOST_WR: begin
        if (!iCoeffiUpdateFlag) begin
          // Window closed: the first read request goes out together with the move into LOAD.
          state_d = LOAD;
          cnt_d   = '0;
          csn_d   = 1'b0;
          addr_d  = LO_ADDR;
        end else if (host_wr_ok) begin
          csn_d  = 1'b0;
          wrn_d  = 1'b0;
          addr_d = iAddrRam;
          wdat_d = iWrDtRam;
        end
      end
      LOAD: begin
        if (!csn_q) begin
          // A read is outstanding: its data arrives next cycle, so strobe its tap next cycle.
          we_d  = 1'b1;
          idx_d = 6'(cnt_q) + 6'd1;
          if (cnt_q != LAST_CNT) begin
            cnt_d  = cnt_q + ONE_A;
            csn_d  = 1'b0;
            addr_d = LO_ADDR + cnt_q + ONE_A;
          end
        end else begin
          // No read outstanding: the final strobe is on the bus now, so the set is complete.
          state_d = RUN;
        end
      end
      RUN: begin
        if (iCoeffiUpdateFlag) state_d = HOST_WR;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == HOST_WR) || (state_d == LOAD);
    en_d   = (state_d == RUN);
    done_d = (state_q == LOAD) && (state_d == RUN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge iClk_12M) begin
    if (!iRsn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      csn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      addr_q  <= '0;
      wdat_q  <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      csn_q   <= csn_d;
      wrn_q   <= wrn_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign oCsnRam   = csn_q;
  assign oWrnRam   = wrn_q;
  assign oAddrRam  = addr_q;
  assign oWrDtRam  = wdat_q;
  assign oCoeffWe  = we_q;
  assign oCoeffIdx = idx_q;
  assign oEnDelay  = en_q;
  assign oEnAcc    = en_q;
  assign oBusy     = busy_q;
  assign oDone     = done_q;

  // The SRAM read port is itself registered, so the tap value is taken straight from it,
  // qualified by the registered strobe; a second register here would push the strobe a cycle late.
  assign oCoeffDt = we_q ? iRdDtRam : '0;

`ifdef FIR_COEFF_CHECKSUM_EN
  logic [COEFF_W+5:0] sum_q, sum_d;

  // Running signed sum; cleared as LOAD is entered, accumulates each strobed tap, holds otherwise.
  always_comb begin
    sum_d = sum_q;
    if (load_entry) begin
      sum_d = '0;
    end else if (we_q) begin
      sum_d = sum_q + {{6{iRdDtRam[COEFF_W-1]}}, iRdDtRam};
    end
  end

  // Checksum register with synchronous active-low reset.
  always_ff @(posedge iClk_12M) begin
    if (!iRsn) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign oChecksum = sum_q;
`else
  logic unused_load_entry;
  assign unused_load_entry = load_entry;
`endif

endmodule
